matmul_seq_ctrl: RTL and testbench

//  Sequencer for the matmul MAC datapath: computes C = A x B with runtime dimensions up to MAX_DIM.

---
 rtl/matmul_pkg.sv | 32 +++
 rtl/matmul_seq_ctrl_if.sv | 28 ++
 rtl/matmul_addr_gen.sv | 60 ++++++
 rtl/matmul_seq_ctrl.sv | 104 ++++++++++
 tb/tb_matmul_seq_ctrl.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/matmul_pkg.sv
// Shared constants, state encodings and the dimension checker for the matmul sequencer.
package matmul_pkg;

    localparam int unsigned MAX_DIM = 256;
    localparam int unsigned DIM_W   = $clog2(MAX_DIM) + 1;
    localparam int unsigned ADDR_W  = $clog2(MAX_DIM * MAX_DIM);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_RUN    = 3'd1;
    localparam logic [2:0] ST_DRAIN1 = 3'd2;
    localparam logic [2:0] ST_DRAIN2 = 3'd3;
    localparam logic [2:0] ST_WRITE  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    typedef enum logic [1:0] {
        ERR_OK       = 2'b00,
        ERR_ZERO     = 2'b01,
        ERR_MISMATCH = 2'b10,
        ERR_RANGE    = 2'b11
    } err_code_t;

    // Zero dims outrank oversize dims, which outrank an inner-dimension mismatch.
    function automatic err_code_t dim_check(input logic [DIM_W-1:0] ar, ac, br, bc);
        logic [DIM_W-1:0] lim;
        lim = DIM_W'(MAX_DIM);
        if (ar == '0 || ac == '0 || br == '0 || bc == '0) return ERR_ZERO;
        if (ar > lim || ac > lim || br > lim || bc > lim) return ERR_RANGE;
        if (ac != br) return ERR_MISMATCH;
        return ERR_OK;
    endfunction

endpackage

// File: rtl/matmul_seq_ctrl_if.sv
// Command, operand-read, MAC-strobe and C-writeback signals of the matmul sequencer.
interface matmul_seq_ctrl_if;
    import matmul_pkg::*;

    logic              start;
    logic [DIM_W-1:0]  a_rows, a_cols, b_rows, b_cols;
    logic              busy, done, err;
    err_code_t         err_code;
    logic              rd_en;
    logic [ADDR_W-1:0] a_addr, b_addr;
    logic              mac_en, mac_clr, mac_last;
    logic              c_valid;
    logic [ADDR_W-1:0] c_addr;
    logic              c_ready;

    modport master (
        input  start, a_rows, a_cols, b_rows, b_cols, c_ready,
        output busy, done, err, err_code, rd_en, a_addr, b_addr,
               mac_en, mac_clr, mac_last, c_valid, c_addr
    );

    modport slave (
        output start, a_rows, a_cols, b_rows, b_cols, c_ready,
        input  busy, done, err, err_code, rd_en, a_addr, b_addr,
               mac_en, mac_clr, mac_last, c_valid, c_addr
    );

endinterface

// File: rtl/matmul_addr_gen.sv
// i/j/k loop counters with incrementally maintained row-major A, B and C addresses.
module matmul_addr_gen
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [DIM_W-1:0]  m_dim,
    input  logic [DIM_W-1:0]  k_dim,
    input  logic [DIM_W-1:0]  n_dim,
    input  logic              clear,
    input  logic              inc_k,
    input  logic              inc_ij,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic [ADDR_W-1:0] c_addr,
    output logic              k_first,
    output logic              k_last,
    output logic              ij_last
);

    logic [DIM_W-1:0]  i, j, k;
    logic [ADDR_W-1:0] a_row;

    assign k_first = (k == '0);
    assign k_last  = (k == k_dim - DIM_W'(1));
    assign ij_last = (i == m_dim - DIM_W'(1)) && (j == n_dim - DIM_W'(1));

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            i      <= '0;
            j      <= '0;
            k      <= '0;
            a_row  <= '0;
            a_addr <= '0;
            b_addr <= '0;
            c_addr <= '0;
        end else if (inc_k) begin
            k      <= k + DIM_W'(1);
            a_addr <= a_addr + ADDR_W'(1);
            b_addr <= b_addr + ADDR_W'(n_dim);
        end else if (inc_ij) begin
            k      <= '0;
            c_addr <= c_addr + ADDR_W'(1);
            if (j == n_dim - DIM_W'(1)) begin
                // Row wrap: A base moves down one row, B restarts at column 0.
                j      <= '0;
                i      <= i + DIM_W'(1);
                a_row  <= a_row + ADDR_W'(k_dim);
                a_addr <= a_row + ADDR_W'(k_dim);
                b_addr <= '0;
            end else begin
                j      <= j + DIM_W'(1);
                a_addr <= a_row;
                b_addr <= ADDR_W'(j) + ADDR_W'(1);
            end
        end
    end

endmodule

// File: rtl/matmul_seq_ctrl.sv
// Top-level sequencer: command validation, loop FSM, MAC strobe pipeline and C writeback.
module matmul_seq_ctrl
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    matmul_seq_ctrl_if.master bus
);

    logic [2:0]       state, state_nxt;
    logic [DIM_W-1:0] m_dim, k_dim, n_dim;
    err_code_t        chk, err_code_q;
    logic             err_q;
    logic             clear, inc_k, inc_ij;
    logic             k_first, k_last, ij_last;
    logic             rd_en;
    logic             mac_en_q, mac_clr_q, mac_last_q;

    assign chk = dim_check(bus.a_rows, bus.a_cols, bus.b_rows, bus.b_cols);

    matmul_addr_gen u_addr_gen (
        .clk     (clk),
        .reset   (reset),
        .m_dim   (m_dim),
        .k_dim   (k_dim),
        .n_dim   (n_dim),
        .clear   (clear),
        .inc_k   (inc_k),
        .inc_ij  (inc_ij),
        .a_addr  (bus.a_addr),
        .b_addr  (bus.b_addr),
        .c_addr  (bus.c_addr),
        .k_first (k_first),
        .k_last  (k_last),
        .ij_last (ij_last)
    );

    // NOTE: every output of this block gets a default first, so no latch can be inferred.
    always_comb begin
        state_nxt = state;
        clear     = 1'b0;
        inc_k     = 1'b0;
        inc_ij    = 1'b0;
        case (state)
            ST_IDLE: if (bus.start) begin
                clear     = 1'b1;
                state_nxt = (chk == ERR_OK) ? ST_RUN : ST_DONE;
            end
            ST_RUN: if (k_last) state_nxt = ST_DRAIN1;
                    else        inc_k     = 1'b1;
            ST_DRAIN1: state_nxt = ST_DRAIN2;
            ST_DRAIN2: state_nxt = ST_WRITE;
            ST_WRITE: if (bus.c_ready) begin
                if (ij_last) state_nxt = ST_DONE;
                else begin
                    inc_ij    = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_IDLE;
            m_dim      <= '0;
            k_dim      <= '0;
            n_dim      <= '0;
            err_code_q <= ERR_OK;
            err_q      <= 1'b0;
            mac_en_q   <= 1'b0;
            mac_clr_q  <= 1'b0;
            mac_last_q <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && bus.start) begin
                m_dim      <= bus.a_rows;
                k_dim      <= bus.a_cols;
                n_dim      <= bus.b_cols;
                err_code_q <= chk;
                err_q      <= (chk != ERR_OK);
            end
            // Operands arrive one cycle after the read, so the MAC strobes trail rd_en.
            mac_en_q   <= rd_en;
            mac_clr_q  <= rd_en && k_first;
            mac_last_q <= rd_en && k_last;
        end
    end

    assign rd_en        = (state == ST_RUN);
    assign bus.rd_en    = rd_en;
    assign bus.busy     = (state == ST_RUN) || (state == ST_DRAIN1) ||
                          (state == ST_DRAIN2) || (state == ST_WRITE);
    assign bus.done     = (state == ST_DONE);
    assign bus.err      = (state == ST_DONE) && err_q;
    assign bus.err_code = err_code_q;
    assign bus.c_valid  = (state == ST_WRITE);
    assign bus.mac_en   = mac_en_q;
    assign bus.mac_clr  = mac_clr_q;
    assign bus.mac_last = mac_last_q;

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Scoreboard bench for matmul_seq_ctrl: expected reads, MAC strobes and C writes are queued per command.
module tb_matmul_seq_ctrl;
    import matmul_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    matmul_seq_ctrl_if bus ();

    matmul_seq_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int a;
        int b;
        bit clr;
        bit last;
    } rd_t;

    rd_t rd_q[$];
    rd_t mac_q[$];
    int  c_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] outs();
        return {bus.busy, bus.done, bus.err, bus.err_code, bus.rd_en, bus.a_addr, bus.b_addr,
                bus.mac_en, bus.mac_clr, bus.mac_last, bus.c_valid, bus.c_addr};
    endfunction

    task automatic push_exp(input int m, input int k, input int n);
        for (int i = 0; i < m; i++)
            for (int j = 0; j < n; j++) begin
                c_q.push_back(i * n + j);
                for (int kk = 0; kk < k; kk++) begin
                    rd_t e;
                    e.a = i * k + kk;
                    e.b = kk * n + j;
                    e.clr = (kk == 0);
                    e.last = (kk == k - 1);
                    rd_q.push_back(e);
                end
            end
    endtask

    // Output monitor, sampling on the falling edge.
    logic        pv, pr;
    logic [15:0] pa;
    always @(negedge clk) begin
        if (reset) begin
            if (mac_q.size() == 0) check("mac_en_extra", bus.mac_en, 0);
            else if (bus.mac_en) begin
                rd_t e;
                e = mac_q.pop_front();
                check("mac_clr", bus.mac_clr, e.clr);
                check("mac_last", bus.mac_last, e.last);
            end
            if (rd_q.size() == 0) check("rd_en_extra", bus.rd_en, 0);
            else if (bus.rd_en) begin
                rd_t e;
                e = rd_q.pop_front();
                check("a_addr", bus.a_addr, e.a);
                check("b_addr", bus.b_addr, e.b);
                mac_q.push_back(e);
            end
            if (c_q.size() == 0) check("c_hs_extra", bus.c_valid & bus.c_ready, 0);
            else if (bus.c_valid && bus.c_ready) check("c_addr", bus.c_addr, c_q.pop_front());
            if (pv && !pr) begin
                check("c_hold_valid", bus.c_valid, 1);
                check("c_hold_addr", bus.c_addr, pa);
            end
            pv <= bus.c_valid;
            pr <= bus.c_ready;
            pa <= bus.c_addr;
        end else begin
            pv <= 1'b0;
            pr <= 1'b0;
            pa <= '0;
        end
    end

    task automatic run_cmd(input int ar, input int ac, input int br, input int bc,
                           input int exp_code, input int stall, input bit mid_start);
        int exp_n, nper, busy_cnt, stall_cnt;
        exp_n = 1;
        if (exp_code == 0) begin
            push_exp(ar, ac, bc);
            exp_n = 1 + ar * bc * (ac + 3) + stall;
        end
        bus.a_rows  = DIM_W'(ar);
        bus.a_cols  = DIM_W'(ac);
        bus.b_rows  = DIM_W'(br);
        bus.b_cols  = DIM_W'(bc);
        bus.start   = 1'b1;
        bus.c_ready = (stall == 0);
        tick();
        bus.start = 1'b0;
        nper = 1;
        busy_cnt = 0;
        stall_cnt = 0;
        while (!bus.done && nper < exp_n + 20) begin
            if (bus.busy) busy_cnt++;
            if (stall > 0 && bus.c_valid && !bus.c_ready) begin
                if (stall_cnt == stall) bus.c_ready = 1'b1;
                else begin
                    check("stall_rd_en", bus.rd_en, 0);
                    stall_cnt++;
                end
            end
            if (mid_start && nper == 50) begin
                bus.a_rows = DIM_W'(1);
                bus.a_cols = DIM_W'(1);
                bus.b_rows = DIM_W'(1);
                bus.b_cols = DIM_W'(1);
            end
            bus.start = mid_start && (nper == 50);
            tick();
            nper++;
        end
        bus.start = 1'b0;
        check("done_cycle", nper, exp_n);
        check("busy_cycles", busy_cnt, exp_n - 1);
        check("busy_at_done", bus.busy, 0);
        check("err_at_done", bus.err, exp_code != 0);
        check("err_code", bus.err_code, exp_code);
        tick();
        check("done_pulse", bus.done, 0);
        check("err_pulse", bus.err, 0);
        check("err_code_held", bus.err_code, exp_code);
        check("rd_q_left", rd_q.size(), 0);
        check("mac_q_left", mac_q.size(), 0);
        check("c_q_left", c_q.size(), 0);
        bus.c_ready = 1'b1;
    endtask

    initial begin
        bus.start   = 1'b0;
        bus.a_rows  = '0;
        bus.a_cols  = '0;
        bus.b_rows  = '0;
        bus.b_cols  = '0;
        bus.c_ready = 1'b1;
        tick();
        tick();
        check("reset_outs", outs(), 0);
        reset = 1'b1;
        tick();
        check("idle_outs", outs(), 0);

        run_cmd(1, 1, 1, 1, 0, 0, 0);
        run_cmd(2, 2, 2, 2, 0, 0, 0);
        run_cmd(100, 100, 50, 50, 2, 0, 0);
        run_cmd(256, 100, 256, 100, 2, 0, 0);
        run_cmd(0, 0, 0, 0, 1, 0, 0);
        run_cmd(257, 4, 4, 4, 3, 0, 0);
        run_cmd(0, 257, 3, 3, 1, 0, 0);
        run_cmd(3, 2, 3, 4, 2, 0, 0);
        run_cmd(2, 2, 2, 2, 0, 5, 0);
        run_cmd(3, 4, 4, 5, 0, 0, 0);
        run_cmd(1, 256, 256, 1, 0, 0, 0);
        run_cmd(256, 1, 1, 2, 0, 0, 0);
        run_cmd(16, 8, 8, 16, 0, 0, 1);

        // Abort a 2x2 command during RUN, then confirm a fresh command still works.
        push_exp(2, 2, 2);
        bus.a_rows = DIM_W'(2);
        bus.a_cols = DIM_W'(2);
        bus.b_rows = DIM_W'(2);
        bus.b_cols = DIM_W'(2);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        check("pre_reset_rd_en", bus.rd_en, 1);
        reset = 1'b0;
        tick();
        check("mid_reset_outs", outs(), 0);
        rd_q.delete();
        mac_q.delete();
        c_q.delete();
        reset = 1'b1;
        tick();
        check("post_reset_outs", outs(), 0);
        run_cmd(1, 1, 1, 1, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
